// File: rtl/execute_pkg.sv
// Shared execute-stage types: multicycle op encoding, multdiv FSM states,
// default multiplier latency and small sign helpers.
package execute_pkg;

   typedef enum logic [2:0] {
      MC_NONE  = 3'd0,
      MC_MULT  = 3'd1,
      MC_MULTU = 3'd2,
      MC_DIV   = 3'd3,
      MC_DIVU  = 3'd4
   } multicycle_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_DONE = 2'd3
   } multdiv_state_t;

   localparam int MUL_LATENCY_DEFAULT = 2;

   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      abs32 = (is_signed && v[31]) ? (32'd0 - v) : v;
   endfunction

   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
      neg_if = neg ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/div_radix2.sv
// Radix-2 restoring divider on 32-bit magnitudes. start loads the operands,
// each step retires one quotient bit; quo_next/rem_next expose the step result.
module div_radix2 (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quo_next,
   output logic [31:0] rem_next
);

   logic [31:0] quo_r;
   logic [31:0] rem_r;
   logic [31:0] div_r;
   logic [32:0] diff_s;

   assign diff_s = {rem_r, quo_r[31]} - {1'b0, div_r};

   // One restoring step: keep the shifted remainder when the trial subtract goes negative
   always_comb begin
      if (diff_s[32]) begin
         rem_next = {rem_r[30:0], quo_r[31]};
         quo_next = {quo_r[30:0], 1'b0};
      end else begin
         rem_next = diff_s[31:0];
         quo_next = {quo_r[30:0], 1'b1};
      end
   end

   // Operand load and per-step update of the quotient/remainder shift pair
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         quo_r <= 32'd0;
         rem_r <= 32'd0;
         div_r <= 32'd0;
      end else if (start) begin
         quo_r <= dividend;
         rem_r <= 32'd0;
         div_r <= divisor;
      end else if (step) begin
         quo_r <= quo_next;
         rem_r <= rem_next;
      end else begin
         quo_r <= quo_r;
         rem_r <= rem_r;
         div_r <= div_r;
      end
   end

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage multiply/divide sequencer: stalls E while an op is in flight and
// presents HI/LO for one released cycle. MULTDIV_DIV_EARLY_EN enables trivial-divide bypass.
module multdiv_ctrl
   import execute_pkg::*;
#(
   parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid_i,
   input  multicycle_t op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        e_stall_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   multdiv_state_t state_r;
   logic [4:0]  cnt_r;
   logic        neg_q_r;
   logic        neg_r_r;

   logic        is_mul_s;
   logic        is_div_s;
   logic        signed_s;
   logic        start_s;
   logic        neg_q_s;
   logic        neg_r_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [63:0] a_ext_s;
   logic [63:0] b_ext_s;
   logic [63:0] mul_issue_s;
   logic [63:0] mul_res_s;
   logic [31:0] quo_nxt_s;
   logic [31:0] rem_nxt_s;
   logic        div_start_s;
   logic        div_step_s;

   // Op decode into class and signedness
   always_comb begin
      is_mul_s = 1'b0;
      is_div_s = 1'b0;
      signed_s = 1'b0;
      case (op_i)
         MC_MULT:  begin is_mul_s = 1'b1; signed_s = 1'b1; end
         MC_MULTU: begin is_mul_s = 1'b1; signed_s = 1'b0; end
         MC_DIV:   begin is_div_s = 1'b1; signed_s = 1'b1; end
         MC_DIVU:  begin is_div_s = 1'b1; signed_s = 1'b0; end
         default:  begin is_mul_s = 1'b0; is_div_s = 1'b0; end
      endcase
   end

   assign start_s = valid_i && (is_mul_s || is_div_s) && !flush_i;
   assign a_mag_s = abs32(a_i, signed_s);
   assign b_mag_s = abs32(b_i, signed_s);
   assign neg_q_s = signed_s && (a_i[31] ^ b_i[31]);
   assign neg_r_s = signed_s && a_i[31];

   // Sign-extending to 64 bits lets one modulo-2^64 multiply serve both MULT and MULTU
   assign a_ext_s     = {{32{signed_s & a_i[31]}}, a_i};
   assign b_ext_s     = {{32{signed_s & b_i[31]}}, b_i};
   assign mul_issue_s = a_ext_s * b_ext_s;

   generate
      if (MUL_LATENCY == 1) begin : g_mul_direct
         assign mul_res_s = mul_issue_s;
      end else begin : g_mul_pipe
         logic [63:0] mul_pipe_r [MUL_LATENCY-1];

         // Product register followed by delay stages; the output register is the last stage
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               for (int i = 0; i < MUL_LATENCY-1; i++) begin
                  mul_pipe_r[i] <= 64'd0;
               end
            end else begin
               mul_pipe_r[0] <= mul_issue_s;
               for (int i = 1; i < MUL_LATENCY-1; i++) begin
                  mul_pipe_r[i] <= mul_pipe_r[i-1];
               end
            end
         end

         assign mul_res_s = mul_pipe_r[MUL_LATENCY-2];
      end
   endgenerate

`ifdef MULTDIV_DIV_EARLY_EN
   logic        early_s;
   logic [31:0] early_q_s;
   assign early_s   = (b_mag_s == 32'd0) || (a_mag_s < b_mag_s);
   assign early_q_s = (b_mag_s == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
`endif

   assign div_start_s = (state_r == MD_IDLE) && start_s && is_div_s;
   assign div_step_s  = (state_r == MD_DIV) && !flush_i;

   div_radix2 u_div (
      .clk      (clk),
      .resetn   (resetn),
      .start    (div_start_s),
      .step     (div_step_s),
      .dividend (a_mag_s),
      .divisor  (b_mag_s),
      .quo_next (quo_nxt_s),
      .rem_next (rem_nxt_s)
   );

   // Stall is combinational so the issue cycle itself holds E
   assign stall_o = resetn && !flush_i &&
                    (((state_r == MD_IDLE) && start_s) ||
                     (state_r == MD_MUL) || (state_r == MD_DIV));

   // Sequencer FSM with registered done/result outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= MD_IDLE;
         cnt_r   <= 5'd0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         done_o  <= 1'b0;
         hi_o    <= 32'd0;
         lo_o    <= 32'd0;
      end else if (flush_i) begin
         state_r <= MD_IDLE;
         cnt_r   <= 5'd0;
         done_o  <= 1'b0;
         hi_o    <= 32'd0;
         lo_o    <= 32'd0;
      end else begin
         case (state_r)
            MD_IDLE: begin
               if (start_s) begin
                  neg_q_r <= neg_q_s;
                  neg_r_r <= neg_r_s;
                  if (is_mul_s && (MUL_LATENCY == 1)) begin
                     state_r <= MD_DONE;
                     done_o  <= 1'b1;
                     hi_o    <= mul_issue_s[63:32];
                     lo_o    <= mul_issue_s[31:0];
                  end else if (is_mul_s) begin
                     state_r <= MD_MUL;
                     cnt_r   <= 5'(MUL_LATENCY - 1);
`ifdef MULTDIV_DIV_EARLY_EN
                  end else if (early_s) begin
                     state_r <= MD_DONE;
                     done_o  <= 1'b1;
                     hi_o    <= neg_if(a_mag_s, neg_r_s);
                     lo_o    <= neg_if(early_q_s, neg_q_s);
`endif
                  end else begin
                     state_r <= MD_DIV;
                     cnt_r   <= 5'd31;
                  end
               end else begin
                  state_r <= MD_IDLE;
               end
            end
            MD_MUL: begin
               // The result leaves the pipe as the count drains to zero
               if (cnt_r == 5'd1) begin
                  state_r <= MD_DONE;
                  cnt_r   <= 5'd0;
                  done_o  <= 1'b1;
                  hi_o    <= mul_res_s[63:32];
                  lo_o    <= mul_res_s[31:0];
               end else begin
                  cnt_r <= cnt_r - 5'd1;
               end
            end
            MD_DIV: begin
               if (cnt_r == 5'd0) begin
                  state_r <= MD_DONE;
                  done_o  <= 1'b1;
                  hi_o    <= neg_if(rem_nxt_s, neg_r_r);
                  lo_o    <= neg_if(quo_nxt_s, neg_q_r);
               end else begin
                  cnt_r <= cnt_r - 5'd1;
               end
            end
            MD_DONE: begin
               if (!e_stall_i) begin
                  state_r <= MD_IDLE;
                  done_o  <= 1'b0;
                  hi_o    <= 32'd0;
                  lo_o    <= 32'd0;
               end else begin
                  state_r <= MD_DONE;
               end
            end
            default: begin
               state_r <= MD_IDLE;
               cnt_r   <= 5'd0;
               done_o  <= 1'b0;
               hi_o    <= 32'd0;
               lo_o    <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: arithmetic reference model checked every
// cycle plus directed vectors with literal results and latencies.
module tb_multdiv_ctrl;
   import execute_pkg::*;

   localparam int MUL_LAT = 2;
`ifdef MULTDIV_DIV_EARLY_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 33;
`endif

   logic        clk;
   logic        resetn;
   logic        valid_i;
   multicycle_t op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        e_stall_i;
   logic        flush_i;
   logic        stall_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int total = 0;
   int bad   = 0;

   multdiv_ctrl #(.MUL_LATENCY(MUL_LAT)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .valid_i   (valid_i),
      .op_i      (op_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .e_stall_i (e_stall_i),
      .flush_i   (flush_i),
      .stall_o   (stall_o),
      .done_o    (done_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference arithmetic: {hi, lo} straight from the instruction semantics
   function automatic logic [63:0] ref_result(multicycle_t op, logic [31:0] a, logic [31:0] b);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         MC_MULT:  ref_result = sa * sb;
         MC_MULTU: ref_result = ua * ub;
         MC_DIVU:  ref_result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
         MC_DIV: begin
            if (b == 32'd0) ref_result = {a, (sa < 0) ? 32'd1 : 32'hFFFF_FFFF};
            else            ref_result = {32'(sa % sb), 32'(sa / sb)};
         end
         default:  ref_result = 64'd0;
      endcase
   endfunction

   function automatic int ref_latency(multicycle_t op, logic [31:0] a, logic [31:0] b);
      if (op == MC_MULT || op == MC_MULTU) return MUL_LAT;
`ifdef MULTDIV_DIV_EARLY_EN
      begin
         logic [31:0] ma;
         logic [31:0] mb;
         ma = (op == MC_DIV && a[31]) ? -a : a;
         mb = (op == MC_DIV && b[31]) ? -b : b;
         if (b == 32'd0 || ma < mb) return 1;
      end
`endif
      return 33;
   endfunction

   function automatic logic is_md(multicycle_t op);
      return op inside {MC_MULT, MC_MULTU, MC_DIV, MC_DIVU};
   endfunction

   // Model: cycles remaining until the result, then a held result window
   logic        m_busy;
   logic        m_done;
   int          m_left;
   logic [63:0] m_res;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         m_res  <= 64'd0;
      end else if (flush_i) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
      end else if (m_done) begin
         if (!e_stall_i) m_done <= 1'b0;
      end else if (m_busy) begin
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
         end else begin
            m_left <= m_left - 1;
         end
      end else if (valid_i && is_md(op_i)) begin
         m_res  <= ref_result(op_i, a_i, b_i);
         m_left <= ref_latency(op_i, a_i, b_i) - 1;
         m_busy <= (ref_latency(op_i, a_i, b_i) > 1);
         m_done <= (ref_latency(op_i, a_i, b_i) == 1);
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      logic        e_stall;
      logic [63:0] e_res;
      e_stall = resetn && !flush_i &&
                (m_busy || (!m_busy && !m_done && valid_i && is_md(op_i)));
      e_res = m_done ? m_res : 64'd0;
      total++;
      if ({stall_o, done_o, hi_o, lo_o} !== {e_stall, m_done, e_res}) begin
         bad++;
         $display("FAIL cycle_model t=%0t got stall=%b done=%b hi=%h lo=%h want stall=%b done=%b hi=%h lo=%h",
                  $time, stall_o, done_o, hi_o, lo_o, e_stall, m_done, e_res[63:32], e_res[31:0]);
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic run_op(input string name, input multicycle_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] want, input int want_lat);
      int          lat;
      int          stalls;
      logic [63:0] got;
      @(posedge clk); #1;
      valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
      lat = -1; stalls = 0; got = 64'd0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (stall_o) stalls++;
         if (done_o) begin
            lat = k;
            got = {hi_o, lo_o};
            break;
         end
      end
      @(posedge clk); #1;
      valid_i = 1'b0; op_i = MC_NONE;
      check({name, "_lat"}, 64'(lat), 64'(want_lat));
      check({name, "_stalls"}, 64'(stalls), 64'(want_lat));
      check({name, "_res"}, got, want);
   endtask

   typedef struct {
      string       name;
      multicycle_t op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{"mult_m1x2",    MC_MULT,  32'hFFFF_FFFF, 32'd2,         64'hFFFF_FFFF_FFFF_FFFE, 2};
      vecs[1]  = '{"multu_m1x2",   MC_MULTU, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, 2};
      vecs[2]  = '{"divu_100_7",   MC_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, 33};
      vecs[3]  = '{"div_m7_2",     MC_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 33};
      vecs[4]  = '{"divu_5_0",     MC_DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, EARLY_LAT};
      vecs[5]  = '{"div_min_m1",   MC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33};
      vecs[6]  = '{"mult_min_min", MC_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2};
      vecs[7]  = '{"div_7_m2",     MC_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33};
      vecs[8]  = '{"div_m5_0",     MC_DIV,   32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_0000_0001, EARLY_LAT};
      vecs[9]  = '{"divu_3_10",    MC_DIVU,  32'd3,         32'd10,        64'h0000_0003_0000_0000, EARLY_LAT};
      vecs[10] = '{"divu_max_1",   MC_DIVU,  32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 33};
      vecs[11] = '{"mult_m3x5",    MC_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 2};
      vecs[12] = '{"div_m100_m7",  MC_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFF_FFFE_0000_000E, 33};

      resetn = 1'b0; valid_i = 1'b0; op_i = MC_NONE; a_i = 32'd0; b_i = 32'd0;
      e_stall_i = 1'b0; flush_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {30'd0, stall_o, done_o, hi_o, lo_o}, 96'd0);
      #1 resetn = 1'b1;

      for (int i = 0; i < 13; i++) begin
         check({vecs[i].name, "_model"}, ref_result(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].res);
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
      end

      // Flush during a divide: no done, then a multiply still works
      begin
         int seen;
         @(posedge clk); #1;
         valid_i = 1'b1; op_i = MC_DIV; a_i = 32'd1000; b_i = 32'd7;
         repeat (10) @(posedge clk);
         #1 flush_i = 1'b1;
         @(negedge clk);
         check("flush_stall", {63'd0, stall_o}, 64'd0);
         @(posedge clk); #1;
         flush_i = 1'b0; valid_i = 1'b0; op_i = MC_NONE;
         seen = 0;
         repeat (40) begin
            @(negedge clk);
            if (done_o) seen++;
         end
         check("flush_no_done", 64'(seen), 64'd0);
         run_op("after_flush_multu", MC_MULTU, 32'd3, 32'd4, 64'd12, 2);
      end

      // Result held while E is stalled by another hazard
      begin
         int          held;
         logic [63:0] first;
         @(posedge clk); #1;
         valid_i = 1'b1; op_i = MC_MULTU; a_i = 32'h0001_0000; b_i = 32'h0001_0000; e_stall_i = 1'b1;
         held = 0; first = 64'd0;
         for (int k = 0; k < 40 && held == 0; k++) begin
            @(negedge clk);
            if (done_o) begin
               held  = 1;
               first = {hi_o, lo_o};
            end
         end
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done_o && {hi_o, lo_o} == first) held++;
         end
         #1 e_stall_i = 1'b0; valid_i = 1'b0; op_i = MC_NONE;
         check("estall_held_cycles", 64'(held), 64'd3);
         check("estall_result", first, 64'h0000_0001_0000_0000);
         @(negedge clk);
         check("estall_release", {63'd0, done_o}, 64'd0);
      end

      // Asynchronous reset in the middle of a divide
      @(posedge clk); #1;
      valid_i = 1'b1; op_i = MC_DIV; a_i = 32'd1000; b_i = 32'd3;
      repeat (5) @(posedge clk);
      #3 resetn = 1'b0;
      #1 check("async_reset", {30'd0, stall_o, done_o, hi_o, lo_o}, 96'd0);
      valid_i = 1'b0; op_i = MC_NONE;
      @(negedge clk); #1 resetn = 1'b1;
      run_op("post_reset_divu", MC_DIVU, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 33);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
